mem_resp_sram: RTL and testbench

Memory-side responder for the core's `mem_valid`/`mem_ready` data bus: the far end of `mem_if`. It accepts one request at a time, holds it for a configurable number of wait states, then commits a byte-strobed write or returns a read word with a one-cycle `mem_ready_o` pulse. It backs the bus with a synchronous word-organised SRAM array and serves as both the on-chip data RAM and the bench memory model.

---
 rtl/mem_resp_sram.sv | 157 +++++++++++++++
 tb/tb_mem_resp_sram.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_resp_sram.sv
// mem_resp_sram: memory-side responder for the mem_valid/mem_ready data bus.
// It takes one request at a time and holds it for WAIT_CYCLES wait states.
// It then commits a byte-strobed write, or returns a read word, into or from
// a synchronous word-wide SRAM array, and pulses mem_ready_o for one cycle.
//
// Handshake: the initiator raises mem_valid_i with the request fields and
// holds them until it samples mem_ready_o=1. The responder samples the bus
// only in IDLE. The commit happens on the edge that enters RESP.
// mem_ready_o is high for exactly the RESP cycle, and the next state is
// always IDLE. As a result, a re-accept can occur no earlier than the edge
// after RESP.
//
// Optional feature macro: MEM_RESP_ERR_EN. When it is defined, the block
// checks the address range. It suppresses out-of-range writes, returns
// 32'hDEAD_BEEF for out-of-range reads, and raises mem_err_o together with
// mem_ready_o. When it is not defined, the index wraps modulo DEPTH_WORDS
// and mem_err_o stays 0.
module mem_resp_sram #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_valid_i,
  input  logic        mem_write_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ready_o,
  output logic        mem_err_o
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  cnt;

  // Request latched at accept
  logic          req_write;
  logic [AW-1:0] req_idx;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wstrb;
  logic          req_oor;

  // Request seen on the bus right now
  logic [31:0]   offset;
  logic [AW-1:0] in_idx;
  logic          in_oor;

  // Request being committed: the bus itself when WAIT_CYCLES=0 commits on
  // the accept edge, otherwise the latched copy.
  logic          cur_write;
  logic [AW-1:0] cur_idx;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_wstrb;
  logic          cur_oor;

  logic        accept;
  logic        commit;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        unused_offset;

  logic [31:0] mem [DEPTH_WORDS];

  assign offset        = mem_addr_i - BASE_ADDR;
  assign in_idx        = offset[AW+1:2];
  assign unused_offset = ^{offset[31:AW+2], offset[1:0]};

`ifdef MEM_RESP_ERR_EN
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
  assign in_oor = (mem_addr_i < BASE_ADDR) || ({1'b0, mem_addr_i} >= END_ADDR);
`else
  assign in_oor = 1'b0;
`endif

  assign accept = (state == ST_IDLE) && mem_valid_i;

  assign cur_write = (state == ST_IDLE) ? mem_write_i : req_write;
  assign cur_idx   = (state == ST_IDLE) ? in_idx      : req_idx;
  assign cur_wdata = (state == ST_IDLE) ? mem_wdata_i : req_wdata;
  assign cur_wstrb = (state == ST_IDLE) ? mem_wstrb_i : req_wstrb;
  assign cur_oor   = (state == ST_IDLE) ? in_oor      : req_oor;

  // Reset has priority over a commit that lands on the same edge
  assign commit = (next_state == ST_RESP) && (state != ST_RESP) && !rst_i;

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (mem_valid_i) next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == 4'd0) next_state = ST_RESP;
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Wait-state counter: loaded at accept, counts down in WAIT
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= CNT_INIT;
    end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Capture the request at accept; the bus is ignored afterwards
  always_ff @(posedge clk_i) begin
    if (accept) begin
      req_write <= mem_write_i;
      req_idx   <= in_idx;
      req_wdata <= mem_wdata_i;
      req_wstrb <= mem_wstrb_i;
      req_oor   <= in_oor;
    end
  end

  // SRAM write port: per-lane byte enables; contents survive reset
  always_ff @(posedge clk_i) begin
    if (commit && cur_write && !cur_oor) begin
      for (int n = 0; n < 4; n++) begin
        if (cur_wstrb[n]) mem[cur_idx][8*n +: 8] <= cur_wdata[8*n +: 8];
      end
    end
  end

  // Read data and error flag, updated only by a committing request
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (commit) begin
      err_q <= cur_oor;
      if (!cur_write) rdata_q <= cur_oor ? 32'hDEAD_BEEF : mem[cur_idx];
    end
  end

  assign mem_rdata_o = rdata_q;
  assign mem_ready_o = (state == ST_RESP);
  assign mem_err_o   = (state == ST_RESP) && err_q;

endmodule

// File: tb/tb_mem_resp_sram.sv
// Directed bench for mem_resp_sram. The instance dut uses the default
// configuration (1024 words, WAIT_CYCLES=1). The instance dut0 uses
// WAIT_CYCLES=0 and serves the back-to-back scenario.
module tb_mem_resp_sram;

  logic        clk;
  logic        rst;

  logic        valid, write;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready, err;

  logic        valid0, write0;
  logic [31:0] addr0, wdata0;
  logic [3:0]  wstrb0;
  logic [31:0] rdata0;
  logic        ready0, err0;

  int tests;
  int fails;

  mem_resp_sram #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) dut (
    .clk_i(clk), .rst_i(rst),
    .mem_valid_i(valid), .mem_write_i(write), .mem_addr_i(addr),
    .mem_wdata_i(wdata), .mem_wstrb_i(wstrb),
    .mem_rdata_o(rdata), .mem_ready_o(ready), .mem_err_o(err)
  );

  mem_resp_sram #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .mem_valid_i(valid0), .mem_write_i(write0), .mem_addr_i(addr0),
    .mem_wdata_i(wdata0), .mem_wstrb_i(wstrb0),
    .mem_rdata_o(rdata0), .mem_ready_o(ready0), .mem_err_o(err0)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver for dut. It is entered and left #1 after a posedge, with the FSM
  // in IDLE. lat counts edges from accept (1) up to the ready cycle, and is
  // -1 when no ready pulse appears within the budget.
  task automatic bus_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] s, output int lat, output logic [31:0] rd,
                         output logic er);
    lat = -1; rd = 'x; er = 'x;
    valid = 1'b1; write = wr; addr = a; wdata = wd; wstrb = s;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) begin lat = i; rd = rdata; er = err; break; end
    end
    valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Driver for dut0, same contract as bus_req
  task automatic bus_req0(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] s, output int lat, output logic [31:0] rd);
    lat = -1; rd = 'x;
    valid0 = 1'b1; write0 = wr; addr0 = a; wdata0 = wd; wstrb0 = s;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ready0 === 1'b1) begin lat = i; rd = rdata0; break; end
    end
    valid0 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1;
    valid = 1'b1; write = 1'b0; addr = 32'h0; wdata = 32'h0; wstrb = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++;
      if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready cyc%0d got %b exp 0", i, ready); end
      tests++;
      if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata cyc%0d got %h exp 00000000", i, rdata); end
      tests++;
      if (ready0 !== 1'b0 || err0 !== 1'b0) begin
        fails++; $display("FAIL reset_dut0 cyc%0d got ready=%b err=%b exp 0/0", i, ready0, err0);
      end
    end
    rst = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) begin lat = i; break; end
    end
    valid = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (lat != 2) begin fails++; $display("FAIL reset_release_latency got %0d exp 2", lat); end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic er;
    bus_req(1'b1, 32'h0, 32'h1122_3344, 4'b1111, lat, rd, er);
    tests++;
    if (lat != 2) begin fails++; $display("FAIL wr_latency got %0d exp 2", lat); end
    tests++;
    if (er !== 1'b0) begin fails++; $display("FAIL wr_err got %b exp 0", er); end
    bus_req(1'b0, 32'h0, 32'h0, 4'b0000, lat, rd, er);
    tests++;
    if (lat != 2) begin fails++; $display("FAIL rd_latency got %0d exp 2", lat); end
    tests++;
    if (rd !== 32'h1122_3344) begin fails++; $display("FAIL rd_data got %h exp 11223344", rd); end
    tests++;
    if (rdata !== 32'h1122_3344) begin fails++; $display("FAIL rd_hold got %h exp 11223344", rdata); end
  endtask

  task automatic test_byte_strobes();
    int lat; logic [31:0] rd; logic er;
    bus_req(1'b1, 32'h4, 32'hAABB_CCDD, 4'b1111, lat, rd, er);
    bus_req(1'b1, 32'h4, 32'h0000_EE00, 4'b0010, lat, rd, er);
    bus_req(1'b0, 32'h4, 32'h0, 4'b0000, lat, rd, er);
    tests++;
    if (rd !== 32'hAABB_EEDD) begin fails++; $display("FAIL strobe_lane1 got %h exp aabbeedd", rd); end
    // Zero strobes: normal response, memory and rdata untouched
    bus_req(1'b1, 32'h4, 32'hFFFF_FFFF, 4'b0000, lat, rd, er);
    tests++;
    if (lat != 2) begin fails++; $display("FAIL strobe_zero_latency got %0d exp 2", lat); end
    tests++;
    if (rd !== 32'hAABB_EEDD) begin fails++; $display("FAIL write_keeps_rdata got %h exp aabbeedd", rd); end
    bus_req(1'b1, 32'h5, 32'h1200_0000, 4'b1000, lat, rd, er);
    bus_req(1'b0, 32'h4, 32'h0, 4'b0000, lat, rd, er);
    tests++;
    if (rd !== 32'h12BB_EEDD) begin fails++; $display("FAIL strobe_lane3 got %h exp 12bbeedd", rd); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic [5:0] seen; logic [31:0] d1, d2; int npulse;
    bus_req0(1'b1, 32'h10, 32'h5A5A_1234, 4'b1111, lat, rd);
    tests++;
    if (lat != 1) begin fails++; $display("FAIL w0_latency got %0d exp 1", lat); end
    bus_req0(1'b1, 32'h14, 32'h0BAD_CAFE, 4'b1111, lat, rd);
    seen = '0; npulse = 0; d1 = 'x; d2 = 'x;
    valid0 = 1'b1; write0 = 1'b0; addr0 = 32'h10; wstrb0 = 4'h0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      seen[i-1] = ready0;
      if (ready0 === 1'b1) begin
        npulse++;
        if (npulse == 1) begin d1 = rdata0; addr0 = 32'h14; end
        else begin d2 = rdata0; valid0 = 1'b0; end
      end
    end
    valid0 = 1'b0;
    tests++;
    if (seen !== 6'b000101) begin fails++; $display("FAIL b2b_pulses got %b exp 000101", seen); end
    tests++;
    if (d1 !== 32'h5A5A_1234) begin fails++; $display("FAIL b2b_data1 got %h exp 5a5a1234", d1); end
    tests++;
    if (d2 !== 32'h0BAD_CAFE) begin fails++; $display("FAIL b2b_data2 got %h exp 0badcafe", d2); end
  endtask

  task automatic test_reset_mid_write();
    int lat; logic [31:0] rd; logic er;
    bus_req(1'b1, 32'h8, 32'h0, 4'b1111, lat, rd, er);
    valid = 1'b1; write = 1'b1; addr = 32'h8; wdata = 32'hFFFF_FFFF; wstrb = 4'b1111;
    @(posedge clk); #1;
    rst = 1'b1; valid = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (ready !== 1'b0) begin fails++; $display("FAIL midrst_ready got %b exp 0", ready); end
    tests++;
    if (rdata !== 32'h0) begin fails++; $display("FAIL midrst_rdata got %h exp 00000000", rdata); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (ready !== 1'b0) begin fails++; $display("FAIL midrst_after_ready got %b exp 0", ready); end
    bus_req(1'b0, 32'h8, 32'h0, 4'b0000, lat, rd, er);
    tests++;
    if (rd !== 32'h0) begin fails++; $display("FAIL midrst_mem got %h exp 00000000", rd); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd; logic er;
    logic [31:0] exp_rd, exp_w0; logic exp_er;
`ifdef MEM_RESP_ERR_EN
    exp_rd = 32'hDEAD_BEEF; exp_er = 1'b1; exp_w0 = 32'h1122_3344;
`else
    exp_rd = 32'h1122_3344; exp_er = 1'b0; exp_w0 = 32'hCAFE_F00D;
`endif
    bus_req(1'b0, 32'h1000, 32'h0, 4'b0000, lat, rd, er);
    tests++;
    if (lat != 2) begin fails++; $display("FAIL oor_latency got %0d exp 2", lat); end
    tests++;
    if (rd !== exp_rd) begin fails++; $display("FAIL oor_rdata got %h exp %h", rd, exp_rd); end
    tests++;
    if (er !== exp_er) begin fails++; $display("FAIL oor_err got %b exp %b", er, exp_er); end
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL oor_err_after got %b exp 0", err); end
    bus_req(1'b1, 32'h1000, 32'hCAFE_F00D, 4'b1111, lat, rd, er);
    bus_req(1'b0, 32'h0, 32'h0, 4'b0000, lat, rd, er);
    tests++;
    if (rd !== exp_w0) begin fails++; $display("FAIL oor_write_effect got %h exp %h", rd, exp_w0); end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1;
    valid = 1'b0; write = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    valid0 = 1'b0; write0 = 1'b0; addr0 = '0; wdata0 = '0; wstrb0 = '0;
    test_reset();
    test_write_read();
    test_byte_strobes();
    test_back_to_back();
    test_reset_mid_write();
    test_out_of_range();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
